// File: rtl/spi_load_ctrl_if.sv
// Pin-level bundle between the external SPI master and the cache loader.
// master: drives chip selects, MOSI and the processor-run flag; observes
//         the write port, status strobes and MISO loopback.
// slave : the loader itself.
interface spi_load_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              csi_n_in;
  logic              csd_n_in;
  logic              mosi_in;
  logic              proc_en_in;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [DATA_W-1:0] wr_data_out;
  logic              icache_wen_out;
  logic              dcache_wen_out;
  logic              busy_out;
  logic              frame_err_out;
  logic              miso_out;

  modport master (
    output csi_n_in, csd_n_in, mosi_in, proc_en_in,
    input  wr_addr_out, wr_data_out, icache_wen_out, dcache_wen_out,
           busy_out, frame_err_out, miso_out
  );

  modport slave (
    input  csi_n_in, csd_n_in, mosi_in, proc_en_in,
    output wr_addr_out, wr_data_out, icache_wen_out, dcache_wen_out,
           busy_out, frame_err_out, miso_out
  );
endinterface

// File: rtl/spi_load_ctrl.sv
// Serial loader: frames MOSI bits (clocked by clk) into {data, addr} words
// under one of two active-low chip selects and issues a one-cycle write
// strobe to the icache or dcache. Frames of the wrong length, dcache
// addresses >= DMEM_SZ and chip-select contention raise a one-cycle
// frame_err pulse. While proc_en_in is high the loader ignores the pins.
// Ports:
//   clk  - core clock, also the serial bit clock
//   rst  - synchronous active-high reset
//   bus  - spi_load_ctrl_if.slave: csi_n/csd_n/mosi/proc_en in;
//          wr_addr/wr_data/icache_wen/dcache_wen/busy/frame_err/miso out
module spi_load_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DMEM_SZ = 15
) (
  input  logic           clk,
  input  logic           rst,
  spi_load_ctrl_if.slave bus
);

  localparam int unsigned FRAME_W = DATA_W + ADDR_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tgt_q, tgt_d;        // 0 = icache, 1 = dcache
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               iwen_q, iwen_d;
  logic               dwen_q, dwen_d;
  logic               err_q, err_d;
  logic               busy_q;
  logic               miso_q;

  logic               one_low;
  logic               both_low;
  logic               tgt_cs_n;
  logic               oth_cs_n;
  logic               frame_ok;
  logic [FRAME_W-1:0] sr_shift;

  assign one_low  = bus.csi_n_in ^ bus.csd_n_in;
  assign both_low = ~bus.csi_n_in & ~bus.csd_n_in;
  assign tgt_cs_n = tgt_q ? bus.csd_n_in : bus.csi_n_in;
  assign oth_cs_n = tgt_q ? bus.csi_n_in : bus.csd_n_in;
  assign sr_shift = {sr_q[FRAME_W-2:0], bus.mosi_in};

  // Judged on the pre-detect count and shift register; the detect cycle never shifts.
  assign frame_ok = (cnt_q == CNT_FULL) &&
                    (!tgt_q || (32'(sr_q[ADDR_W-1:0]) < DMEM_SZ));

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    iwen_d  = 1'b0;
    dwen_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.proc_en_in) begin
          if (one_low) begin
            sr_d    = sr_shift;
            cnt_d   = CNT_W'(1);
            tgt_d   = bus.csi_n_in;
            state_d = SHIFT;
          end else if (both_low) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end

      SHIFT: begin
        if (bus.proc_en_in) begin
          state_d = IDLE;
        end else if (tgt_cs_n) begin
          if (frame_ok) begin
            addr_d  = sr_q[ADDR_W-1:0];
            data_d  = sr_q[FRAME_W-1:ADDR_W];
            iwen_d  = ~tgt_q;
            dwen_d  = tgt_q;
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = oth_cs_n ? IDLE : DRAIN;
          end
        end else if (!oth_cs_n) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          sr_d  = sr_shift;
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end

      // Strobe cycle; a single low chip select here opens the next frame.
      COMMIT: begin
        if (!bus.proc_en_in && one_low) begin
          sr_d    = sr_shift;
          cnt_d   = CNT_W'(1);
          tgt_d   = bus.csi_n_in;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      DRAIN: begin
        if (bus.csi_n_in && bus.csd_n_in) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      iwen_q  <= 1'b0;
      dwen_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      iwen_q  <= iwen_d;
      dwen_q  <= dwen_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      miso_q  <= sr_q[FRAME_W-1];
    end
  end

  assign bus.wr_addr_out    = addr_q;
  assign bus.wr_data_out    = data_q;
  assign bus.icache_wen_out = iwen_q;
  assign bus.dcache_wen_out = dwen_q;
  assign bus.frame_err_out  = err_q;
  assign bus.busy_out       = busy_q;
  assign bus.miso_out       = miso_q;

endmodule

// File: tb/tb_spi_load_ctrl.sv
// Bench for spi_load_ctrl: per-cycle pin stimulus tables, a frame-level
// reference model, and one task per scenario with its own comparisons.
module tb_spi_load_ctrl;

  localparam int MAXC = 160;
  localparam int IW = 16;
  localparam int DW = 15;
  localparam int ER = 14;
  localparam int BZ = 13;
  localparam int MI = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_load_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  spi_load_ctrl #(.DATA_W(8), .ADDR_W(4), .DMEM_SZ(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {iwen, dwen, err, busy, miso, addr[3:0], data[7:0]}
  logic [16:0] obs;
  assign obs = {bus.icache_wen_out, bus.dcache_wen_out, bus.frame_err_out,
                bus.busy_out, bus.miso_out, bus.wr_addr_out, bus.wr_data_out};

  int total;
  int bad;
  int n;
  bit s_csi [MAXC];
  bit s_csd [MAXC];
  bit s_mosi[MAXC];
  bit s_pe  [MAXC];
  logic [16:0] got_w[MAXC];
  logic [16:0] exp_w[MAXC];
  bit m_iwen[MAXC];
  bit m_dwen[MAXC];
  bit m_err [MAXC];
  bit m_busy[MAXC];
  bit m_samp[MAXC];
  bit m_upd [MAXC];
  logic [11:0] m_word[MAXC];

  function automatic void add_cyc(bit csi, bit csd, bit mosi, bit pe);
    if (n < MAXC) begin
      s_csi[n] = csi; s_csd[n] = csd; s_mosi[n] = mosi; s_pe[n] = pe;
      n++;
    end
  endfunction

  // to_d: 0 selects csi_n, 1 selects csd_n; bits sent MSB first.
  function automatic void add_frame(bit to_d, logic [31:0] val, int len, bit pe);
    for (int i = len - 1; i >= 0; i--) add_cyc(to_d, !to_d, val[i], pe);
  endfunction

  function automatic void add_idle(int k);
    for (int i = 0; i < k; i++) add_cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
  endfunction

  // Busy until a cycle with both selects high; returns the next free cycle.
  function automatic int drain_from(int c0);
    int c = c0;
    m_busy[c] = 1'b1;
    c++;
    while (c < n && !(s_csi[c] && s_csd[c])) begin
      m_busy[c] = 1'b1;
      c++;
    end
    if (c < n) c++;
    return c;
  endfunction

  // Frame-level reference: collects bits per frame and judges each frame end.
  function automatic void model_run();
    int c;
    int w;
    bit commit;
    bit tgt;
    bit fin;
    bit tcs;
    bit ocs;
    bit bits[$];
    bit h[$];
    logic [3:0] a;
    logic [7:0] d;
    for (int i = 0; i < MAXC; i++) begin
      m_iwen[i] = 0; m_dwen[i] = 0; m_err[i] = 0; m_busy[i] = 0;
      m_samp[i] = 0; m_upd[i] = 0; m_word[i] = '0;
    end
    c = 0;
    commit = 0;
    while (c < n) begin
      if (s_pe[c] || (s_csi[c] && s_csd[c]) || (commit && !s_csi[c] && !s_csd[c])) begin
        commit = 0;
        c++;
        continue;
      end
      commit = 0;
      if (!s_csi[c] && !s_csd[c]) begin
        m_err[c] = 1;
        c = drain_from(c);
        continue;
      end
      tgt = s_csi[c];
      bits.delete();
      bits.push_back(s_mosi[c]);
      m_samp[c] = 1; m_busy[c] = 1;
      c++;
      fin = 0;
      while (c < n && !fin) begin
        tcs = tgt ? s_csd[c] : s_csi[c];
        ocs = tgt ? s_csi[c] : s_csd[c];
        if (s_pe[c]) begin
          c++;
          fin = 1;
        end else if (tcs) begin
          w = 0;
          foreach (bits[i]) w = w * 2 + int'(bits[i]);
          if (bits.size() == 12 && (!tgt || (w % 16) < 15)) begin
            m_upd[c] = 1; m_word[c] = 12'(w); m_busy[c] = 1;
            if (tgt) m_dwen[c] = 1; else m_iwen[c] = 1;
            commit = 1;
            c++;
          end else begin
            m_err[c] = 1;
            if (!ocs) c = drain_from(c);
            else c++;
          end
          fin = 1;
        end else if (!ocs) begin
          m_err[c] = 1;
          c = drain_from(c);
          fin = 1;
        end else begin
          bits.push_back(s_mosi[c]);
          m_samp[c] = 1; m_busy[c] = 1;
          c++;
        end
      end
    end
    // MISO replays the bit sampled twelve samples earlier (zeros after reset).
    a = '0; d = '0;
    h.delete();
    for (int i = 0; i < 12; i++) h.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (m_upd[i]) begin a = m_word[i][3:0]; d = m_word[i][11:4]; end
      exp_w[i] = {m_iwen[i], m_dwen[i], m_err[i], m_busy[i], h[h.size() - 12], a, d};
      if (m_samp[i]) h.push_back(s_mosi[i]);
    end
  endfunction

  // Reset, then apply the table; got_w[c] holds outputs just after edge c.
  task automatic run_seq();
    @(negedge clk);
    rst = 1'b1;
    bus.csi_n_in = 1'b1; bus.csd_n_in = 1'b1; bus.mosi_in = 1'b0; bus.proc_en_in = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.csi_n_in = s_csi[c]; bus.csd_n_in = s_csd[c];
      bus.mosi_in = s_mosi[c]; bus.proc_en_in = s_pe[c];
      @(posedge clk);
      #1;
      got_w[c] = obs;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.csi_n_in = 1'b1; bus.csd_n_in = 1'b1; bus.mosi_in = 1'b0; bus.proc_en_in = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (obs !== 17'h0) begin bad++; $display("FAIL reset_state got=%05h exp=00000", obs); end
    @(negedge clk);
    bus.csi_n_in = 1'b0; bus.mosi_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (obs !== 17'h0) begin bad++; $display("FAIL reset_held cyc=%0d got=%05h exp=00000", i, obs); end
    end
    @(negedge clk);
    bus.csi_n_in = 1'b1;
  endtask

  task automatic test_icache_load();
    n = 0;
    add_frame(1'b0, 32'hA53, 12, 1'b0);
    add_idle(3);
    for (int k = 0; k < 3; k++) begin
      add_frame(1'b0, 32'($urandom_range(0, 4095)), 12, 1'b0);
      add_idle(int'($urandom_range(1, 3)));
    end
    model_run();
    run_seq();
    for (int c = 0; c < n; c++) begin
      total++;
      if (got_w[c] !== exp_w[c]) begin bad++; $display("FAIL icache_model cyc=%0d got=%05h exp=%05h", c, got_w[c], exp_w[c]); end
    end
    total++;
    if (got_w[11][IW] !== 1'b0) begin bad++; $display("FAIL icache_wen_early got=%b exp=0", got_w[11][IW]); end
    total++;
    if (got_w[12][IW] !== 1'b1) begin bad++; $display("FAIL icache_wen_t2 got=%b exp=1", got_w[12][IW]); end
    total++;
    if (got_w[12][11:0] !== 12'h3A5) begin bad++; $display("FAIL icache_addr_data got=%03h exp=3a5", got_w[12][11:0]); end
    total++;
    if (got_w[12][DW] !== 1'b0) begin bad++; $display("FAIL icache_no_dwen got=%b exp=0", got_w[12][DW]); end
    total++;
    if (got_w[13][BZ] !== 1'b0) begin bad++; $display("FAIL icache_busy_fall got=%b exp=0", got_w[13][BZ]); end
  endtask

  task automatic test_back_to_back();
    n = 0;
    add_frame(1'b1, 32'h7F2, 12, 1'b0);
    add_idle(1);
    add_frame(1'b1, 32'h01E, 12, 1'b0);
    add_idle(1);
    for (int k = 0; k < 4; k++) begin
      add_frame(1'($urandom_range(0, 1)),
                32'({8'($urandom_range(0, 255)), 4'($urandom_range(0, 14))}), 12, 1'b0);
      add_idle(1);
    end
    add_idle(2);
    model_run();
    run_seq();
    for (int c = 0; c < n; c++) begin
      total++;
      if (got_w[c] !== exp_w[c]) begin bad++; $display("FAIL b2b_model cyc=%0d got=%05h exp=%05h", c, got_w[c], exp_w[c]); end
    end
    total++;
    if ({got_w[12][DW], got_w[12][11:0]} !== 13'h1_27F) begin
      bad++; $display("FAIL b2b_first got=%04h exp=127f", {got_w[12][DW], got_w[12][11:0]});
    end
    total++;
    if ({got_w[25][DW], got_w[25][11:0]} !== 13'h1_E01) begin
      bad++; $display("FAIL b2b_second got=%04h exp=1e01", {got_w[25][DW], got_w[25][11:0]});
    end
    total++;
    if ({got_w[13][DW], got_w[24][DW]} !== 2'b00) begin
      bad++; $display("FAIL b2b_spacing got=%b exp=00", {got_w[13][DW], got_w[24][DW]});
    end
  endtask

  task automatic test_length_err();
    int v;
    int nerr;
    int nwen;
    v = int'($urandom_range(0, 4095));
    n = 0;
    add_frame(1'b0, 32'(v), 12, 1'b0);
    add_idle(2);
    add_frame(1'b0, 32'($urandom), 11, 1'b0);
    add_idle(2);
    add_frame(1'b1, 32'($urandom), 13, 1'b0);
    add_idle(3);
    model_run();
    run_seq();
    nerr = 0; nwen = 0;
    for (int c = 0; c < n; c++) begin
      total++;
      if (got_w[c] !== exp_w[c]) begin bad++; $display("FAIL len_model cyc=%0d got=%05h exp=%05h", c, got_w[c], exp_w[c]); end
      nerr += int'(got_w[c][ER]);
      nwen += int'(got_w[c][IW]) + int'(got_w[c][DW]);
    end
    total++;
    if ({got_w[25][ER], got_w[40][ER]} !== 2'b11) begin
      bad++; $display("FAIL len_err_pulses got=%b exp=11", {got_w[25][ER], got_w[40][ER]});
    end
    total++;
    if (nerr !== 2 || nwen !== 1) begin bad++; $display("FAIL len_counts got=%0d/%0d exp=2/1", nerr, nwen); end
    total++;
    if (got_w[n-1][11:0] !== {4'(v % 16), 8'(v / 16)}) begin
      bad++; $display("FAIL len_hold got=%03h exp=%03h", got_w[n-1][11:0], {4'(v % 16), 8'(v / 16)});
    end
  endtask

  task automatic test_dcache_addr();
    int ndw;
    n = 0;
    add_frame(1'b1, 32'h55F, 12, 1'b0);
    add_idle(2);
    add_frame(1'b0, 32'h55F, 12, 1'b0);
    add_idle(3);
    model_run();
    run_seq();
    ndw = 0;
    for (int c = 0; c < n; c++) begin
      total++;
      if (got_w[c] !== exp_w[c]) begin bad++; $display("FAIL daddr_model cyc=%0d got=%05h exp=%05h", c, got_w[c], exp_w[c]); end
      ndw += int'(got_w[c][DW]);
    end
    total++;
    if (got_w[12][ER] !== 1'b1 || ndw !== 0) begin
      bad++; $display("FAIL daddr_reject got=err%b/dwen%0d exp=err1/dwen0", got_w[12][ER], ndw);
    end
    total++;
    if ({got_w[26][IW], got_w[26][11:0]} !== 13'h1_F55) begin
      bad++; $display("FAIL daddr_icache_f got=%04h exp=1f55", {got_w[26][IW], got_w[26][11:0]});
    end
  endtask

  task automatic test_contention_abort();
    int nerr;
    n = 0;
    add_frame(1'b0, 32'($urandom), 6, 1'b0);        // cycles 0..5
    for (int i = 0; i < 3; i++) add_cyc(1'b0, 1'b0, 1'b1, 1'b0);  // 6..8 both low
    for (int i = 0; i < 2; i++) add_cyc(1'b0, 1'b1, 1'b1, 1'b0);  // 9..10 csi only
    add_idle(2);                                      // 11..12
    add_frame(1'b0, 32'($urandom), 5, 1'b0);        // 13..17
    add_frame(1'b0, 32'($urandom), 4, 1'b1);        // 18..21 proc_en abort
    add_idle(2);                                      // 22..23
    add_frame(1'b0, 32'($urandom), 12, 1'b1);       // 24..35 ignored
    add_cyc(1'b1, 1'b1, 1'b0, 1'b1);                 // 36
    add_idle(2);                                      // 37..38
    model_run();
    run_seq();
    nerr = 0;
    for (int c = 0; c < n; c++) begin
      total++;
      if (got_w[c] !== exp_w[c]) begin bad++; $display("FAIL cont_model cyc=%0d got=%05h exp=%05h", c, got_w[c], exp_w[c]); end
      nerr += int'(got_w[c][ER]);
    end
    total++;
    if ({got_w[6][ER], got_w[10][BZ], got_w[11][BZ]} !== 3'b110) begin
      bad++; $display("FAIL cont_drain got=%b exp=110", {got_w[6][ER], got_w[10][BZ], got_w[11][BZ]});
    end
    total++;
    if (nerr !== 1) begin bad++; $display("FAIL cont_err_count got=%0d exp=1", nerr); end
    for (int c = 18; c < n; c++) begin
      total++;
      if (got_w[c][16:13] !== 4'b0000) begin
        bad++; $display("FAIL proc_en_quiet cyc=%0d got=%b exp=0000", c, got_w[c][16:13]);
      end
    end
  endtask

  task automatic test_random();
    int k;
    n = 0;
    for (int it = 0; it < 6; it++) begin
      k = int'($urandom_range(0, 5));
      if (k <= 2) begin
        add_frame(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), 12, 1'b0);
      end else if (k == 3) begin
        add_frame(1'($urandom_range(0, 1)), 32'($urandom), int'($urandom_range(10, 14)), 1'b0);
      end else if (k == 4) begin
        add_frame(1'($urandom_range(0, 1)), 32'($urandom), 4, 1'b0);
        add_cyc(1'b0, 1'b0, 1'b0, 1'b0);
        add_cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        add_frame(1'b1, 32'($urandom), 5, 1'b0);
        add_frame(1'b1, 32'($urandom), 2, 1'b1);
      end
      add_idle(int'($urandom_range(1, 2)));
    end
    model_run();
    run_seq();
    for (int c = 0; c < n; c++) begin
      total++;
      if (got_w[c] !== exp_w[c]) begin bad++; $display("FAIL random_model cyc=%0d got=%05h exp=%05h", c, got_w[c], exp_w[c]); end
    end
  endtask

  task automatic test_reset_loopback();
    logic [11:0] pat;
    n = 0;
    add_frame(1'b0, 32'($urandom), 6, 1'b0);
    model_run();
    run_seq();
    for (int c = 0; c < n; c++) begin
      total++;
      if (got_w[c] !== exp_w[c]) begin bad++; $display("FAIL prereset_model cyc=%0d got=%05h exp=%05h", c, got_w[c], exp_w[c]); end
    end
    // Reset lands mid-frame with the select still low.
    @(negedge clk);
    rst = 1'b1;
    bus.mosi_in = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (obs !== 17'h0) begin bad++; $display("FAIL midreset_clear got=%05h exp=00000", obs); end
    @(negedge clk);
    rst = 1'b0;
    bus.csi_n_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (obs[16:13] !== 4'b0000) begin bad++; $display("FAIL midreset_quiet cyc=%0d got=%b exp=0000", i, obs[16:13]); end
    end

    pat = 12'hC3A;
    n = 0;
    add_frame(1'b0, {8'h0, pat, 12'($urandom)}, 24, 1'b0);
    add_idle(3);
    model_run();
    run_seq();
    for (int c = 0; c < n; c++) begin
      total++;
      if (got_w[c] !== exp_w[c]) begin bad++; $display("FAIL loop_model cyc=%0d got=%05h exp=%05h", c, got_w[c], exp_w[c]); end
    end
    for (int k2 = 0; k2 < 12; k2++) begin
      total++;
      if (got_w[k2 + 12][MI] !== pat[11 - k2]) begin
        bad++; $display("FAIL loop_miso bit=%0d got=%b exp=%b", k2, got_w[k2 + 12][MI], pat[11 - k2]);
      end
    end
    total++;
    if (got_w[24][ER] !== 1'b1) begin bad++; $display("FAIL overrun_err got=%b exp=1", got_w[24][ER]); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    n = 0;
    rst = 1'b1;
    bus.csi_n_in = 1'b1;
    bus.csd_n_in = 1'b1;
    bus.mosi_in = 1'b0;
    bus.proc_en_in = 1'b0;
    test_reset();
    test_icache_load();
    test_back_to_back();
    test_length_err();
    test_dcache_addr();
    test_contention_abort();
    test_random();
    test_reset_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_load_ctrl.md
Name: spi_load_ctrl

Overview:
Serial program/data loader between the external SPI master pins and the processor's instruction and data caches. It frames MOSI bits into address/data words under the two active-low chip selects and validates frame length and target. It issues a single-cycle write strobe to either the icache or the dcache. It is idle and transparent while the processor is executing; SCLK is the core clk, so every bit is sampled on a clk rising edge.

Parameters:
DATA_W, 8, cache word width
ADDR_W, 4, cache address width; frame length FRAME_W = DATA_W+ADDR_W (12)
DMEM_SZ, 15, number of valid dcache entries; dcache addresses >= DMEM_SZ are rejected

Ports:
clk  in  1  core clock, also the serial bit clock
rst  in  1  synchronous, active-high reset
csi_n_in  in  1  icache chip select, active low
csd_n_in  in  1  dcache chip select, active low
mosi_in  in  1  serial data, first bit = frame MSB
proc_en_in  in  1  processor running; loader must not accept frames
wr_addr_out  out  ADDR_W  latched write address
wr_data_out  out  DATA_W  latched write data
icache_wen_out  out  1  one-cycle icache write strobe
dcache_wen_out  out  1  one-cycle dcache write strobe
busy_out  out  1  high in any state other than IDLE
frame_err_out  out  1  one-cycle pulse on a rejected frame
miso_out  out  1  loopback: bit shifted out of shift register MSB

Behaviour:
- Reset: state IDLE, shift reg 0, bit count 0, target 0. wr_addr/wr_data 0; both wen 0, busy 0, frame_err 0, miso 0. A reset mid-frame discards the frame with no write and no error.
- Shift reg sr[FRAME_W-1:0] shifts left: sr <= {sr[FRAME_W-2:0], mosi_in}. After 12 bits, sr[11:4] = data and sr[3:0] = addr. miso_out = registered sr[11] (the bit received 12 samples earlier).
- Bit counter is 4 bits and saturates at FRAME_W+1; any count above FRAME_W marks overrun.
- States IDLE, SHIFT, COMMIT, DRAIN.
- IDLE:
  - proc_en_in=1: stay in IDLE and ignore the chip selects.
  - Exactly one cs_n low: sample that cycle's mosi as bit 1 (count=1), latch target (0=icache, 1=dcache), go to SHIFT.
  - Both cs_n low: pulse frame_err, go to DRAIN.
- SHIFT:
  - Target cs_n still low and the other cs_n high: shift, count++ (saturating).
  - Target cs_n high: the frame ends. Valid if count==FRAME_W and (target==icache or sr[3:0] < DMEM_SZ). If valid, latch wr_addr=sr[3:0] and wr_data=sr[11:4], go to COMMIT. Otherwise pulse frame_err, go to IDLE (or DRAIN if the other cs_n is low).
  - Other cs_n goes low mid-frame: pulse frame_err, go to DRAIN.
  - proc_en_in rises: abort silently (no write, no error), go to IDLE.
- COMMIT:
  - Exactly one cycle; assert the selected wen. wr_addr/wr_data are stable this cycle.
  - Latency: last bit at cycle t, cs_n high detected at t+1, wen high at t+2.
  - If exactly one cs_n is low in COMMIT, this cycle starts a new frame exactly as IDLE would (count=1, next SHIFT). This is the back-to-back case; the minimum cs_n high gap is 1 cycle.
  - Otherwise go to IDLE.
- DRAIN: wait until both cs_n are high, then go to IDLE. No shifting, no writes.
- Only one wen may be high at a time. frame_err_out and the wen strobes are registered, never both high.
- The validity check uses the count and sr before the detect-cycle shift; the detect cycle does not shift.

Test Plan:
- icache load: csi_n low 12 cycles with bits 0xA5 then 0x3 (MSB first), then high. Required: icache_wen=1 exactly at t+2, wr_data=0xA5, wr_addr=0x3, dcache_wen=0, busy falls the cycle after.
- Back-to-back dcache: frame {0x7F, 0x2}, 1-cycle gap, then {0x01, 0xE}. Required: two dcache_wen pulses 13 cycles apart with (0x2,0x7F) then (0xE,0x01).
- Length errors: an 11-bit frame, then a 13-bit frame. Required: frame_err pulse for each, no wen, wr_addr/wr_data keep their previous values.
- Dcache address 0xF: 12-bit frame {0x55, 0xF} on csd_n. Required: frame_err=1, dcache_wen never asserted. The same frame on csi_n writes icache addr 0xF.
- Contention and abort: csd_n falls while an icache frame is mid-way. Required: frame_err pulse, DRAIN until both are high, no writes. proc_en_in=1 mid-frame gives a silent return to IDLE; csi_n activity while proc_en_in=1 gives busy=0 and no wen.
- Reset and loopback: rst asserted at bit 6 gives all outputs 0 next cycle and no write. After 12 bits of pattern 0xC3A, miso_out replays the bits 12 cycles later.
